rbus_conf_receiver: RTL and testbench

RBUS_CONF_RECEIVER -- requirements
Module: RBUS_CONF_RECEIVER

---
 rtl/rbus_conf_receiver.sv | 153 +++++++++++++++
 tb/tb_rbus_conf_receiver.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbus_conf_receiver.sv
// rbus_conf_receiver: configuration-word receiver for the RBUS initiator handshake.
// Captures a burst of configuration words into local storage and validates the
// word count against the initiator's expectation. It then acknowledges the
// initiator or flags an error, and finally presents the stored configuration
// as ready.
// Optional feature: define RBUS_CONF_RECEIVER_PARITY_EN to add a per-word even
// parity input. A parity mismatch on any captured word rejects the configuration.
module rbus_conf_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  RBUS_CONF_RECEIVER_Clk,
  input  logic                  RBUS_CONF_RECEIVER_Reset,
  input  logic                  RBUS_CONF_RECEIVER_Conf_Rutine,
  input  logic                  RBUS_CONF_RECEIVER_Conf_Valid,
  input  logic [DATA_WIDTH-1:0] RBUS_CONF_RECEIVER_Conf_Data,
`ifdef RBUS_CONF_RECEIVER_PARITY_EN
  input  logic                  RBUS_CONF_RECEIVER_Conf_Parity,
`endif
  input  logic                  RBUS_CONF_RECEIVER_Set_Conf_Already,
  input  logic [ADDR_WIDTH:0]   RBUS_CONF_RECEIVER_Expected_Count,
  input  logic [ADDR_WIDTH-1:0] RBUS_CONF_RECEIVER_Rd_Addr,
  output logic                  RBUS_CONF_RECEIVER_Conf_Already_Ok,
  output logic                  RBUS_CONF_RECEIVER_Conf_Error,
  output logic                  RBUS_CONF_RECEIVER_Bus_Ready,
  output logic [ADDR_WIDTH:0]   RBUS_CONF_RECEIVER_Word_Count,
  output logic [DATA_WIDTH-1:0] RBUS_CONF_RECEIVER_Rd_Data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_CHECK   = 3'd2,
    S_ACK     = 3'd3,
    S_ERROR   = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  perr_q, perr_d;
  logic                  rut_prev_q;
  logic                  rut_rise;
  logic                  wr_en;
  logic                  par_bad;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  assign rut_rise = RBUS_CONF_RECEIVER_Conf_Rutine & ~rut_prev_q;

`ifdef RBUS_CONF_RECEIVER_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign par_bad = (^RBUS_CONF_RECEIVER_Conf_Data) != RBUS_CONF_RECEIVER_Conf_Parity;
`else
  assign par_bad = 1'b0;
`endif

  // Next-state, count and sticky-flag logic for the configuration handshake.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    perr_d  = perr_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RBUS_CONF_RECEIVER_Conf_Rutine) begin
          state_d = S_CAPTURE;
          count_d = '0;
          ovf_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (RBUS_CONF_RECEIVER_Set_Conf_Already || RBUS_CONF_RECEIVER_Conf_Rutine) begin
          // A word arriving alongside the end request is still taken.
          if (RBUS_CONF_RECEIVER_Conf_Valid) begin
            if (count_q == FULL_COUNT) begin
              ovf_d = 1'b1;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + 1'b1;
            end
            if (par_bad) perr_d = 1'b1;
          end
          if (RBUS_CONF_RECEIVER_Set_Conf_Already) state_d = S_CHECK;
        end else begin
          // Routine abandoned by the initiator: drop the partial transfer.
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      S_CHECK: begin
        if (count_q == RBUS_CONF_RECEIVER_Expected_Count && !ovf_q && !perr_q)
          state_d = S_ACK;
        else
          state_d = S_ERROR;
      end
      S_ACK: begin
        if (!RBUS_CONF_RECEIVER_Set_Conf_Already) state_d = S_DONE;
      end
      S_ERROR, S_DONE: begin
        // Only a fresh routine start (edge, not level) restarts capture.
        if (rut_rise) begin
          state_d = S_CAPTURE;
          count_d = '0;
          ovf_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge RBUS_CONF_RECEIVER_Clk or negedge RBUS_CONF_RECEIVER_Reset) begin
    if (!RBUS_CONF_RECEIVER_Reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
      rut_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
      rut_prev_q <= RBUS_CONF_RECEIVER_Conf_Rutine;
    end
  end

  // Word storage; contents survive reset and are never cleared.
  always_ff @(posedge RBUS_CONF_RECEIVER_Clk) begin
    if (wr_en) mem_q[count_q[ADDR_WIDTH-1:0]] <= RBUS_CONF_RECEIVER_Conf_Data;
  end

  // Registered read port; a same-cycle write to the read slot returns the old word.
  always_ff @(posedge RBUS_CONF_RECEIVER_Clk or negedge RBUS_CONF_RECEIVER_Reset) begin
    if (!RBUS_CONF_RECEIVER_Reset) rd_data_q <= '0;
    else                           rd_data_q <= mem_q[RBUS_CONF_RECEIVER_Rd_Addr];
  end

  assign RBUS_CONF_RECEIVER_Conf_Already_Ok = (state_q == S_ACK);
  assign RBUS_CONF_RECEIVER_Conf_Error      = (state_q == S_ERROR);
  assign RBUS_CONF_RECEIVER_Bus_Ready       = (state_q == S_DONE);
  assign RBUS_CONF_RECEIVER_Word_Count      = count_q;
  assign RBUS_CONF_RECEIVER_Rd_Data         = rd_data_q;

endmodule

// File: tb/tb_rbus_conf_receiver.sv
// Testbench for rbus_conf_receiver: directed scenarios plus randomized transfers
// checked against a transaction-level reference model of the handshake.
module tb_rbus_conf_receiver;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rut, vld, set;
  logic [DW-1:0] data;
  logic          par;
  logic [AW:0]   expc;
  logic [AW-1:0] rd_addr;
  logic          ok, err, rdy;
  logic [AW:0]   wc;
  logic [DW-1:0] rd;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_known [DEPTH];
  logic [DW-1:0] words [32];
  int            bad_idx = -1;

  rbus_conf_receiver #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .RBUS_CONF_RECEIVER_Clk            (clk),
    .RBUS_CONF_RECEIVER_Reset          (rst_n),
    .RBUS_CONF_RECEIVER_Conf_Rutine    (rut),
    .RBUS_CONF_RECEIVER_Conf_Valid     (vld),
    .RBUS_CONF_RECEIVER_Conf_Data      (data),
`ifdef RBUS_CONF_RECEIVER_PARITY_EN
    .RBUS_CONF_RECEIVER_Conf_Parity    (par),
`endif
    .RBUS_CONF_RECEIVER_Set_Conf_Already(set),
    .RBUS_CONF_RECEIVER_Expected_Count (expc),
    .RBUS_CONF_RECEIVER_Rd_Addr        (rd_addr),
    .RBUS_CONF_RECEIVER_Conf_Already_Ok(ok),
    .RBUS_CONF_RECEIVER_Conf_Error     (err),
    .RBUS_CONF_RECEIVER_Bus_Ready      (rdy),
    .RBUS_CONF_RECEIVER_Word_Count     (wc),
    .RBUS_CONF_RECEIVER_Rd_Data        (rd)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One complete configuration transfer; outcome predicted from the count rules.
  task automatic do_transfer(input int n, input int exp_cnt, input bit merge,
                             input int gap_max, input string tag);
    int  cnt;
    bit  ovf, perr, pass;
    int  hold;
    cnt  = (n > DEPTH) ? DEPTH : n;
    ovf  = (n > DEPTH);
    perr = 1'b0;
`ifdef RBUS_CONF_RECEIVER_PARITY_EN
    perr = (bad_idx >= 0) && (bad_idx < n);
`endif
    pass = (cnt == exp_cnt) && !ovf && !perr;
    expc = (AW+1)'(exp_cnt);
    rut = 1'b0; vld = 1'b0; set = 1'b0;
    tick;
    rut = 1'b1;
    tick;
    checks++;
    if ({ok, err, rdy, wc} !== {3'b000, (AW+1)'(0)}) begin
      errors++;
      $display("FAIL %s start: ok/err/rdy/wc got %b%b%b/%0d want 000/0", tag, ok, err, rdy, wc);
    end
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        vld = 1'b0;
        tick;
      end
      vld  = 1'b1;
      data = words[i];
      par  = (^words[i]) ^ (i == bad_idx);
      set  = merge && (i == n - 1);
      tick;
    end
    vld = 1'b0;
    if (!(merge && n > 0)) begin
      set = 1'b1;
      tick;
    end
    checks++;
    if ({ok, err, rdy} !== 3'b000) begin
      errors++;
      $display("FAIL %s check_cycle: ok/err/rdy got %b%b%b want 000", tag, ok, err, rdy);
    end
    checks++;
    if (wc !== (AW+1)'(cnt)) begin
      errors++;
      $display("FAIL %s word_count: got %0d want %0d", tag, wc, cnt);
    end
    tick;
    checks++;
    if ({ok, err, rdy} !== (pass ? 3'b100 : 3'b010)) begin
      errors++;
      $display("FAIL %s verdict: ok/err/rdy got %b%b%b want %b", tag, ok, err, rdy,
               pass ? 3'b100 : 3'b010);
    end
    if (pass) begin
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        tick;
        checks++;
        if (ok !== 1'b1) begin
          errors++;
          $display("FAIL %s ack_hold: ok got %b want 1", tag, ok);
        end
      end
      set = 1'b0;
      tick;
      checks++;
      if ({ok, err, rdy} !== 3'b001) begin
        errors++;
        $display("FAIL %s done: ok/err/rdy got %b%b%b want 001", tag, ok, err, rdy);
      end
    end else begin
      set = 1'b0;
      tick;
      tick;
      checks++;
      if ({ok, err} !== 2'b01) begin
        errors++;
        $display("FAIL %s error_hold: ok/err got %b%b want 01", tag, ok, err);
      end
    end
    for (int i = 0; i < cnt; i++) begin
      mdl_mem[i]   = words[i];
      mdl_known[i] = 1'b1;
    end
  endtask

  task automatic check_reads(input int k, input string tag);
    int a;
    for (int j = 0; j < k; j++) begin
      a = $urandom_range(0, DEPTH - 1);
      if (mdl_known[a]) begin
        rd_addr = AW'(a);
        tick;
        checks++;
        if (rd !== mdl_mem[a]) begin
          errors++;
          $display("FAIL %s read[%0d]: got %h want %h", tag, a, rd, mdl_mem[a]);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rut = 1'b0; vld = 1'b0; set = 1'b0; data = '0; par = 1'b0;
    expc = '0; rd_addr = '0;
    #3;
    checks++;
    if ({ok, err, rdy, wc, rd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ok/err/rdy/wc/rd got %b%b%b/%0d/%h want all 0",
               ok, err, rdy, wc, rd);
    end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 9; i++) words[i] = DW'(i + 1);
    do_transfer(9, 9, 1'b0, 0, "basic");
    rd_addr = 4'd4;
    tick;
    checks++;
    if (rd !== 8'h05) begin
      errors++;
      $display("FAIL basic_read4: got %h want 05", rd);
    end
  endtask

  task automatic test_short;
    for (int i = 0; i < 8; i++) words[i] = DW'($urandom);
    do_transfer(8, 9, 1'b0, 1, "short");
    rut = 1'b0;
    tick;
    rut = 1'b1;
    tick;
    checks++;
    if ({err, wc} !== {1'b0, (AW+1)'(0)}) begin
      errors++;
      $display("FAIL short_restart: err/wc got %b/%0d want 0/0", err, wc);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 17; i++) words[i] = DW'($urandom);
    do_transfer(17, 16, 1'b0, 0, "overflow");
    rd_addr = 4'd15;
    tick;
    checks++;
    if (rd !== words[15]) begin
      errors++;
      $display("FAIL overflow_slot15: got %h want %h", rd, words[15]);
    end
  endtask

  task automatic test_merge;
    for (int i = 0; i < 3; i++) words[i] = DW'($urandom);
    do_transfer(3, 3, 1'b1, 0, "merge");
  endtask

  task automatic test_abort;
    rut = 1'b0;
    tick;
    rut = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      words[i] = DW'($urandom);
      vld = 1'b1; data = words[i]; par = ^words[i];
      tick;
      mdl_mem[i] = words[i];
      mdl_known[i] = 1'b1;
    end
    vld = 1'b0;
    rut = 1'b0;
    tick;
    checks++;
    if ({ok, err, rdy, wc} !== {3'b000, (AW+1)'(0)}) begin
      errors++;
      $display("FAIL abort: ok/err/rdy/wc got %b%b%b/%0d want 000/0", ok, err, rdy, wc);
    end
    check_reads(4, "abort");
  endtask

  task automatic test_reset_ack;
    words[0] = DW'($urandom);
    words[1] = DW'($urandom);
    expc = 5'd2;
    rut = 1'b0;
    tick;
    rut = 1'b1;
    tick;
    for (int i = 0; i < 2; i++) begin
      vld = 1'b1; data = words[i]; par = ^words[i];
      tick;
      mdl_mem[i] = words[i];
      mdl_known[i] = 1'b1;
    end
    vld = 1'b0;
    set = 1'b1;
    tick;
    tick;
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_ack_pre: ok got %b want 1", ok);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ok, err, rdy, wc, rd} !== '0) begin
      errors++;
      $display("FAIL rst_ack_async: ok/err/rdy/wc/rd got %b%b%b/%0d/%h want all 0",
               ok, err, rdy, wc, rd);
    end
    set = 1'b0;
    rut = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick;
    checks++;
    if ({ok, err, rdy, wc} !== {3'b000, (AW+1)'(0)}) begin
      errors++;
      $display("FAIL rst_ack_idle: ok/err/rdy/wc got %b%b%b/%0d want 000/0", ok, err, rdy, wc);
    end
    check_reads(4, "rst_ack");
  endtask

  task automatic test_parity;
    for (int i = 0; i < 4; i++) words[i] = DW'($urandom);
    bad_idx = 1;
    do_transfer(4, 4, 1'b0, 0, "parity");
    bad_idx = -1;
  endtask

  task automatic test_random;
    int n, e;
    bit m;
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) words[i] = DW'($urandom);
      if ($urandom_range(0, 1) == 1) e = (n > DEPTH) ? DEPTH : n;
      else                           e = $urandom_range(0, DEPTH);
      m = (n > 0) && ($urandom_range(0, 1) == 1);
      do_transfer(n, e, m, 2, "random");
      check_reads(3, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_known[i] = 1'b0;
    test_reset;
    test_basic;
    test_short;
    test_overflow;
    test_merge;
    test_abort;
    test_reset_ack;
    test_parity;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
